controlador_memoria_datos: RTL and testbench

CONTROLADOR_MEMORIA_DATOS -- requirements
Module: controlador_memoria_datos

---
 rtl/controlador_memoria_datos.sv | 180 ++++++++++++++++++
 tb/tb_controlador_memoria_datos.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_memoria_datos.sv
// -----------------------------------------------------------------------------
// controlador_memoria_datos
//
// Purpose:
//   Data-memory controller for a pipelined core. It does two independent jobs:
//     1. Pipeline access path (purely combinational): forwards address and
//        store data to the memory, derives byte enables, flags illegal
//        (misaligned or reserved-size) accesses and sign/zero-extends loads.
//     2. Debug dump engine: on a start request it sweeps every word of the
//        memory once and streams each word out with a valid/ready handshake.
//        Each word takes at least two cycles (SETUP then SEND).
//
// Ports:
//   i_clock, i_reset            clock (posedge), async active-high reset
//   i_mem_read, i_mem_write     pipeline load / store request
//   i_mem_size                  00 byte, 01 half, 10 word, 11 reserved
//   i_mem_unsigned              zero-extend loads when 1
//   i_addr, i_wr_data           pipeline byte address / store data (lane 0)
//   o_load_data                 extended load result
//   o_misaligned                illegal access flag
//   o_mem_write_enable          memory write enable
//   o_mem_byte_enb              memory byte enables
//   o_mem_direcc, o_mem_data    memory address / write data
//   i_mem_data                  memory read data
//   o_mem_direcc_debug          memory debug address (word counter * 4)
//   i_mem_data_debug            memory debug read data
//   i_debug_start               dump start request (honoured only when idle)
//   o_debug_data, o_debug_valid dumped word and its valid flag
//   i_debug_ready               consumer accepts the current word
//   o_debug_busy                dump in progress
//   o_debug_done                one-cycle pulse when the sweep completes
// -----------------------------------------------------------------------------
module controlador_memoria_datos #(
  parameter int NB_DATA   = 32,
  parameter int NUM_SLOTS = 128,
  parameter int NUM_DIREC = $clog2(NUM_SLOTS),
  parameter int NUM_WORDS = NUM_SLOTS / 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_mem_size,
  input  logic                 i_mem_unsigned,
  input  logic [NUM_DIREC-1:0] i_addr,
  input  logic [NB_DATA-1:0]   i_wr_data,
  output logic [NB_DATA-1:0]   o_load_data,
  output logic                 o_misaligned,
  output logic                 o_mem_write_enable,
  output logic [3:0]           o_mem_byte_enb,
  output logic [NUM_DIREC-1:0] o_mem_direcc,
  output logic [NB_DATA-1:0]   o_mem_data,
  input  logic [NB_DATA-1:0]   i_mem_data,
  output logic [NUM_DIREC-1:0] o_mem_direcc_debug,
  input  logic [NB_DATA-1:0]   i_mem_data_debug,
  input  logic                 i_debug_start,
  output logic [NB_DATA-1:0]   o_debug_data,
  output logic                 o_debug_valid,
  input  logic                 i_debug_ready,
  output logic                 o_debug_busy,
  output logic                 o_debug_done
);

  localparam int NB_CNT = $clog2(NUM_WORDS);
  localparam logic [NB_CNT-1:0] LAST_WORD = NB_CNT'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SEND, DONE} state_t;

  state_t            state;
  logic [NB_CNT-1:0] word_cnt;

  logic              access;
  logic              size_ok;
  logic [3:0]        size_enb;
  logic              load_ok;

  // Sign bit of the narrow lane is replicated unless the load is unsigned.
  function automatic logic [NB_DATA-1:0] ext_byte(input logic [7:0] lane,
                                                  input logic       uns);
    logic signed [7:0] s_lane;
    s_lane = $signed(lane);
    return {{(NB_DATA-8){s_lane[7] & ~uns}}, lane};
  endfunction

  function automatic logic [NB_DATA-1:0] ext_half(input logic [15:0] lane,
                                                  input logic        uns);
    logic signed [15:0] s_lane;
    s_lane = $signed(lane);
    return {{(NB_DATA-16){s_lane[15] & ~uns}}, lane};
  endfunction

  // Pipeline access path: fully combinational, independent of the dump FSM.
  assign o_mem_direcc = i_addr;
  assign o_mem_data   = i_wr_data;
  assign access       = i_mem_read | i_mem_write;

  always_comb begin
    size_ok  = 1'b0;
    size_enb = 4'b0000;
    case (i_mem_size)
      2'b00: begin size_ok = 1'b1;                size_enb = 4'b0001; end
      2'b01: begin size_ok = ~i_addr[0];          size_enb = 4'b0011; end
      2'b10: begin size_ok = (i_addr[1:0] == 2'b00); size_enb = 4'b1111; end
      default: begin size_ok = 1'b0;              size_enb = 4'b0000; end
    endcase
  end

  assign o_misaligned       = access & ~size_ok;
  assign o_mem_byte_enb     = (access & size_ok) ? size_enb : 4'b0000;
  assign o_mem_write_enable = i_mem_write & size_ok;
  // A simultaneous read and write is treated as a store, so no load result.
  assign load_ok            = i_mem_read & ~i_mem_write & size_ok;

  always_comb begin
    o_load_data = '0;
    if (load_ok) begin
      case (i_mem_size)
        2'b00:   o_load_data = ext_byte(i_mem_data[7:0], i_mem_unsigned);
        2'b01:   o_load_data = ext_half(i_mem_data[15:0], i_mem_unsigned);
        default: o_load_data = i_mem_data;
      endcase
    end
  end

  // Debug dump: the address tracks the word counter in every state.
  assign o_mem_direcc_debug = NUM_DIREC'({word_cnt, 2'b00});

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      word_cnt      <= '0;
      o_debug_data  <= '0;
      o_debug_valid <= 1'b0;
      o_debug_done  <= 1'b0;
      o_debug_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_debug_done <= 1'b0;
          if (i_debug_start) begin
            state        <= SETUP;
            word_cnt     <= '0;
            o_debug_busy <= 1'b1;
          end
        end
        // One cycle for the memory to present the addressed word.
        SETUP: begin
          o_debug_data  <= i_mem_data_debug;
          o_debug_valid <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          if (i_debug_ready) begin
            o_debug_valid <= 1'b0;
            if (word_cnt == LAST_WORD) begin
              state        <= DONE;
              o_debug_done <= 1'b1;
            end else begin
              state    <= SETUP;
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        // Counter is left on the last word so the sweep never wraps.
        DONE: begin
          o_debug_done <= 1'b0;
          o_debug_busy <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state         <= IDLE;
          o_debug_valid <= 1'b0;
          o_debug_done  <= 1'b0;
          o_debug_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_memoria_datos.sv
// -----------------------------------------------------------------------------
// tb_controlador_memoria_datos
//
// Self-checking bench for controlador_memoria_datos. A behavioural model of
// the access rules (byte counts, alignment by modulo, masking) and a word
// queue model of the dump sweep produce every expected value.
// -----------------------------------------------------------------------------
module tb_controlador_memoria_datos;

  localparam int NB_DATA   = 32;
  localparam int NUM_SLOTS = 128;
  localparam int NUM_DIREC = $clog2(NUM_SLOTS);
  localparam int NUM_WORDS = NUM_SLOTS / 4;

  logic                 clk;
  logic                 rst;
  logic                 rd, wr, uns;
  logic [1:0]           size;
  logic [NUM_DIREC-1:0] addr;
  logic [NB_DATA-1:0]   wdata, mdata;
  logic [NB_DATA-1:0]   load_data;
  logic                 misaligned, we;
  logic [3:0]           benb;
  logic [NUM_DIREC-1:0] mem_addr, dbg_addr;
  logic [NB_DATA-1:0]   mem_wdata, dbg_rdata, dbg_data;
  logic                 dbg_start, dbg_valid, dbg_ready, dbg_busy, dbg_done;

  logic [NB_DATA-1:0]   dmem [NUM_WORDS];

  int n_tests = 0;
  int n_fail  = 0;

  controlador_memoria_datos #(
    .NB_DATA(NB_DATA), .NUM_SLOTS(NUM_SLOTS),
    .NUM_DIREC(NUM_DIREC), .NUM_WORDS(NUM_WORDS)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_mem_read(rd), .i_mem_write(wr), .i_mem_size(size),
    .i_mem_unsigned(uns), .i_addr(addr), .i_wr_data(wdata),
    .o_load_data(load_data), .o_misaligned(misaligned),
    .o_mem_write_enable(we), .o_mem_byte_enb(benb),
    .o_mem_direcc(mem_addr), .o_mem_data(mem_wdata), .i_mem_data(mdata),
    .o_mem_direcc_debug(dbg_addr), .i_mem_data_debug(dbg_rdata),
    .i_debug_start(dbg_start), .o_debug_data(dbg_data),
    .o_debug_valid(dbg_valid), .i_debug_ready(dbg_ready),
    .o_debug_busy(dbg_busy), .o_debug_done(dbg_done)
  );

  // Debug port of the bench memory: word-indexed, combinational read.
  assign dbg_rdata = dmem[dbg_addr[NUM_DIREC-1:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model of the access path: bytes = 2**size, legal when the
  // address is a multiple of the access size.
  task automatic check_pipe();
    int          nb;
    bit          acc, mis;
    logic [31:0] mask, exp_load;
    logic [3:0]  exp_be;
    acc = rd || wr;
    nb  = (size == 2'd3) ? 0 : (1 << size);
    mis = acc && (nb == 0 || (int'(addr) % nb) != 0);
    exp_be   = (acc && !mis) ? 4'((1 << nb) - 1) : 4'b0000;
    exp_load = 32'h0;
    if (rd && !wr && !mis) begin
      mask     = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
      exp_load = mdata & mask;
      if (!uns && nb < 4 && mdata[8 * nb - 1]) exp_load = exp_load | ~mask;
    end
    chk("misaligned", {31'b0, misaligned}, {31'b0, mis});
    chk("byte_enb", {28'b0, benb}, {28'b0, exp_be});
    chk("write_enable", {31'b0, we}, {31'b0, wr && !mis});
    chk("load_data", load_data, exp_load);
    chk("mem_direcc", {25'b0, mem_addr}, {25'b0, addr});
    chk("mem_data", mem_wdata, wdata);
  endtask

  task automatic drive_pipe_random();
    rd    = 1'($urandom_range(0, 1));
    wr    = 1'($urandom_range(0, 1));
    size  = 2'($urandom_range(0, 3));
    uns   = 1'($urandom_range(0, 1));
    addr  = NUM_DIREC'($urandom_range(0, NUM_SLOTS - 1));
    wdata = $urandom;
    mdata = $urandom;
  endtask

  task automatic set_pipe(input bit r, input bit w, input logic [1:0] s, input bit u,
                          input logic [NUM_DIREC-1:0] a, input logic [31:0] md);
    rd = r; wr = w; size = s; uns = u; addr = a; mdata = md; wdata = $urandom;
    #1;
  endtask

  // One dump run. Expected words are taken in order from the bench memory;
  // rnd_ready randomises the consumer, stall_word holds ready low for five
  // cycles on that word, abort_word asserts reset when that word is valid,
  // restart pulses start again mid-sweep.
  task automatic run_dump(input bit rnd_ready, input int stall_word,
                          input int abort_word, input bit restart);
    int idx, c, stall, done_cnt;
    bit stalled, fin;
    idx = 0; stall = 0; stalled = 0; done_cnt = 0; fin = 0;
    @(negedge clk); dbg_start = 1'b1; dbg_ready = 1'b0;
    @(negedge clk); dbg_start = 1'b0;
    c = 1;
    while (!fin) begin
      drive_pipe_random(); #1; check_pipe();
      if (abort_word >= 0 && dbg_valid && idx == abort_word) begin
        rst = 1'b1; #1;
        chk("abort_data", dbg_data, 32'h0);
        chk("abort_valid", {31'b0, dbg_valid}, 32'h0);
        chk("abort_busy", {31'b0, dbg_busy}, 32'h0);
        chk("abort_done", {31'b0, dbg_done}, 32'h0);
        chk("abort_dbg_addr", {25'b0, dbg_addr}, 32'h0);
        chk("abort_comb_addr", {25'b0, mem_addr}, {25'b0, addr});
        @(negedge clk); rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", {31'b0, dbg_done}, 32'h0);
          chk("abort_idle", {31'b0, dbg_busy}, 32'h0);
        end
        fin = 1;
      end else begin
        if (dbg_done) begin
          done_cnt++;
          chk("done_all_words", idx, NUM_WORDS);
          if (!rnd_ready && stall_word < 0) chk("done_cycle", c, 2 * NUM_WORDS + 1);
        end else if (done_cnt > 0) begin
          chk("busy_after_done", {31'b0, dbg_busy}, 32'h0);
          chk("done_pulses", done_cnt, 1);
          fin = 1;
        end else begin
          chk("busy_in_dump", {31'b0, dbg_busy}, 32'h1);
        end
        if (!fin) begin
          if (stalled && idx == stall_word) chk("stall_valid", {31'b0, dbg_valid}, 32'h1);
          if (dbg_valid) begin
            chk("dump_data", dbg_data, dmem[idx]);
            chk("dump_addr", {25'b0, dbg_addr}, idx * 4);
          end
          if (stall > 0) begin
            dbg_ready = 1'b0; stall--;
          end else if (dbg_valid && idx == stall_word && !stalled) begin
            dbg_ready = 1'b0; stall = 4; stalled = 1;
          end else if (rnd_ready) begin
            dbg_ready = ($urandom_range(0, 3) != 0);
          end else begin
            dbg_ready = 1'b1;
          end
          dbg_start = restart && (c == 20 || c == 21);
          if (dbg_valid && dbg_ready) idx++;
          @(negedge clk); c++;
          if (c > 2000) begin
            chk("dump_timeout", 32'h0, 32'h1);
            fin = 1;
          end
        end
      end
    end
    dbg_start = 1'b0; dbg_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd = 0; wr = 0; size = 0; uns = 0; addr = 7'h55;
    wdata = 0; mdata = 0; dbg_start = 0; dbg_ready = 0;
    for (int k = 0; k < NUM_WORDS; k++) dmem[k] = k;
    #1;
    chk("rst_data", dbg_data, 32'h0);
    chk("rst_valid", {31'b0, dbg_valid}, 32'h0);
    chk("rst_busy", {31'b0, dbg_busy}, 32'h0);
    chk("rst_done", {31'b0, dbg_done}, 32'h0);
    chk("rst_dbg_addr", {25'b0, dbg_addr}, 32'h0);
    chk("rst_comb_addr", {25'b0, mem_addr}, 32'h55);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed access cases
    set_pipe(1, 0, 2'b00, 0, 7'h08, 32'h0000_00F0);
    chk("lb_enb", {28'b0, benb}, 32'h1);
    chk("lb_signed", load_data, 32'hFFFF_FFF0);
    set_pipe(1, 0, 2'b00, 1, 7'h08, 32'h0000_00F0);
    chk("lbu", load_data, 32'h0000_00F0);
    set_pipe(0, 1, 2'b10, 0, 7'h0A, 32'h0);
    chk("sw_mis", {31'b0, misaligned}, 32'h1);
    chk("sw_enb", {28'b0, benb}, 32'h0);
    chk("sw_we", {31'b0, we}, 32'h0);
    set_pipe(0, 1, 2'b01, 0, 7'h0A, 32'h0);
    chk("sh_enb", {28'b0, benb}, 32'h3);
    chk("sh_we", {31'b0, we}, 32'h1);
    set_pipe(1, 1, 2'b10, 0, 7'h04, 32'h1234_5678);
    chk("rw_load_zero", load_data, 32'h0);
    chk("rw_we", {31'b0, we}, 32'h1);
    set_pipe(1, 0, 2'b01, 0, 7'h06, 32'h0000_8001);
    chk("lh_signed", load_data, 32'hFFFF_8001);
    set_pipe(1, 0, 2'b11, 0, 7'h00, 32'h1);
    chk("reserved_mis", {31'b0, misaligned}, 32'h1);

    // Randomised access path against the model
    for (int i = 0; i < 40; i++) begin
      drive_pipe_random(); #1; check_pipe();
    end

    run_dump(0, -1, -1, 0);   // full sweep, ready tied high
    run_dump(0,  3, -1, 0);   // ready held low on word 3
    run_dump(0, -1, 10, 0);   // reset mid-sweep
    run_dump(0, -1, -1, 0);   // restarts from word 0
    for (int k = 0; k < NUM_WORDS; k++) dmem[k] = $urandom;
    run_dump(1, -1, -1, 0);   // random consumer, random contents
    run_dump(0, -1, -1, 1);   // second start mid-sweep is ignored

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
